caesar_arbiter: RTL

Shares one `caesar_decryption` engine between `NUM_CH` independent requesters, each with its own programmable decryption key. Each channel gets a one-entry holding buffer. A round-robin scheduler dispatches buffered bytes to the engine together with that channel's key. A tag pipeline matched to the engine latency re-labels each decrypted byte with its source channel. The block sits between the channel producers and the engine; the engine's ports connect directly to the `eng_*` ports.

---
 rtl/caesar_arb_pkg.sv | 18 +
 rtl/caesar_rr_arbiter.sv | 34 +++
 rtl/caesar_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/caesar_arb_pkg.sv
// caesar_arb_pkg: shared constants, channel-index width helper and the return-path tag type.
package caesar_arb_pkg;
  localparam int D_WIDTH_DEF   = 8;
  localparam int KEY_WIDTH_DEF = 16;
  localparam int NUM_CH_DEF    = 4;
  localparam int ENG_LAT_DEF   = 1;
  localparam int TAG_CH_W      = 4;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sized for the largest supported channel count so the type is parameter-independent.
  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] ch;
  } tag_t;
endpackage

// File: rtl/caesar_rr_arbiter.sv
// caesar_rr_arbiter: combinational one-of-N grant; round-robin from ptr_i, or lowest index wins
// when CAESAR_ARB_FIXED_PRIO_EN is defined (ptr_i then does not exist).
module caesar_rr_arbiter
  import caesar_arb_pkg::*;
#(
  parameter int  NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
`ifndef CAESAR_ARB_FIXED_PRIO_EN
  input  logic [CH_W-1:0]   ptr_i,
`endif
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);
  int c;

  // Scanning from the far end and overwriting leaves the first requester in search order.
  always_comb begin
    idx_o = '0;
    c     = 0;
    any_o = |req_i;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
`ifdef CAESAR_ARB_FIXED_PRIO_EN
      c = i;
`else
      c = (int'(ptr_i) + i) % NUM_CH;
`endif
      if (req_i[c]) idx_o = CH_W'(c);
    end
    gnt_o = any_o ? (NUM_CH'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/caesar_arbiter.sv
// caesar_arbiter: shares one caesar_decryption engine between NUM_CH keyed requesters.
// CAESAR_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module caesar_arbiter
  import caesar_arb_pkg::*;
#(
  parameter int  D_WIDTH   = D_WIDTH_DEF,
  parameter int  KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int  NUM_CH    = NUM_CH_DEF,
  parameter int  ENG_LAT   = ENG_LAT_DEF,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*D_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  output logic [NUM_CH-1:0]         ch_busy_o,
  input  logic                      key_wr_i,
  input  logic [CH_W-1:0]           key_ch_i,
  input  logic [KEY_WIDTH-1:0]      key_i,
  output logic [D_WIDTH-1:0]        eng_data_o,
  output logic [KEY_WIDTH-1:0]      eng_key_o,
  output logic                      eng_valid_o,
  input  logic                      eng_busy_i,
  input  logic [D_WIDTH-1:0]        eng_data_i,
  input  logic                      eng_valid_i,
  output logic [D_WIDTH-1:0]        data_o,
  output logic [CH_W-1:0]           ch_id_o,
  output logic                      valid_o
);
  logic [NUM_CH-1:0]    pending_q, pending_d;
  logic [D_WIDTH-1:0]   buf_q [NUM_CH];
  logic [D_WIDTH-1:0]   buf_d [NUM_CH];
  logic [KEY_WIDTH-1:0] key_q [NUM_CH];
  logic [KEY_WIDTH-1:0] key_d [NUM_CH];
  logic [D_WIDTH-1:0]   eng_data_q, eng_data_d;
  logic [KEY_WIDTH-1:0] eng_key_q, eng_key_d;
  logic                 eng_valid_q, eng_valid_d;
  tag_t                 eng_tag_q, eng_tag_d;
  tag_t                 tag_q [ENG_LAT];
  tag_t                 tag_d [ENG_LAT];
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic [CH_W-1:0]      ch_id_q, ch_id_d;
  logic                 valid_q, valid_d;
  logic [NUM_CH-1:0]    gnt;
  logic [CH_W-1:0]      idx;
  logic                 any, grant, hit;
`ifndef CAESAR_ARB_FIXED_PRIO_EN
  logic [CH_W-1:0]      ptr_q, ptr_d;
`endif

  caesar_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i (pending_q),
`ifndef CAESAR_ARB_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (gnt),
    .idx_o (idx),
    .any_o (any)
  );

  assign grant = any && !eng_busy_i;
  assign hit   = eng_valid_i && tag_q[ENG_LAT-1].valid;

  // Accept only into empty buffers; a granted buffer is pending, so accept and clear never collide.
  always_comb begin
    buf_d     = buf_q;
    key_d     = key_q;
    pending_d = pending_q & ~(grant ? gnt : '0);
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_valid_i[k] && !pending_q[k]) begin
        buf_d[k]     = ch_data_i[k*D_WIDTH +: D_WIDTH];
        pending_d[k] = 1'b1;
      end
    end
    if (key_wr_i && int'(key_ch_i) < NUM_CH) key_d[key_ch_i] = key_i;
    eng_valid_d = grant;
    eng_data_d  = grant ? buf_q[idx] : eng_data_q;
    eng_key_d   = grant ? key_q[idx] : eng_key_q;
    eng_tag_d   = '{valid: grant, ch: TAG_CH_W'(idx)};
    tag_d[0]    = eng_tag_q;
    for (int i = 1; i < ENG_LAT; i++) tag_d[i] = tag_q[i-1];
    valid_d = hit;
    data_d  = hit ? eng_data_i : data_q;
    ch_id_d = hit ? tag_q[ENG_LAT-1].ch[CH_W-1:0] : ch_id_q;
`ifndef CAESAR_ARB_FIXED_PRIO_EN
    ptr_d = grant ? ((int'(idx) == NUM_CH - 1) ? '0 : idx + 1'b1) : ptr_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      buf_q       <= '{default: '0};
      key_q       <= '{default: '0};
      eng_data_q  <= '0;
      eng_key_q   <= '0;
      eng_valid_q <= 1'b0;
      eng_tag_q   <= '0;
      tag_q       <= '{default: '0};
      data_q      <= '0;
      ch_id_q     <= '0;
      valid_q     <= 1'b0;
`ifndef CAESAR_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      pending_q   <= pending_d;
      buf_q       <= buf_d;
      key_q       <= key_d;
      eng_data_q  <= eng_data_d;
      eng_key_q   <= eng_key_d;
      eng_valid_q <= eng_valid_d;
      eng_tag_q   <= eng_tag_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      ch_id_q     <= ch_id_d;
      valid_q     <= valid_d;
`ifndef CAESAR_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign ch_busy_o   = pending_q;
  assign eng_data_o  = eng_data_q;
  assign eng_key_o   = eng_key_q;
  assign eng_valid_o = eng_valid_q;
  assign data_o      = data_q;
  assign ch_id_o     = ch_id_q;
  assign valid_o     = valid_q;
endmodule
